// File: rtl/map_write_arbiter.sv
// map_write_arbiter
// Funnels single-cycle map-tile write pulses from several writers onto the one
// map_mem write port. Each writer has its own small FIFO, so a write is never
// lost to contention. It is lost only when its FIFO overflows, and that loss is
// flagged. The FIFOs are drained one entry per cycle in round-robin order.
module map_write_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 2,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_REQ-1:0]            req_we,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  output logic                          mem_we,
  output logic [ADDR_WIDTH-1:0]         mem_addr,
  output logic [DATA_WIDTH-1:0]         mem_data,
  output logic [NUM_REQ-1:0]            wr_done,
  output logic [NUM_REQ-1:0]            overflow,
  output logic                          busy
);

  localparam int ENTRY_W = ADDR_WIDTH + DATA_WIDTH;
  localparam int PTR_W   = $clog2(FIFO_DEPTH);
  localparam int CNT_W   = PTR_W + 1;
  localparam int IDX_W   = $clog2(NUM_REQ);

  // Per-FIFO status and head entries, gathered for the arbiter
  logic [NUM_REQ-1:0]         nonempty;
  logic [NUM_REQ*ENTRY_W-1:0] head_flat;

  // Arbitration results (combinational, from registered FIFO state)
  logic                       grant_valid;
  logic [IDX_W-1:0]           grant_idx;
  logic [NUM_REQ-1:0]         grant_onehot;
  logic [ENTRY_W-1:0]         grant_entry;

  // Round-robin pointer and output registers
  logic [IDX_W-1:0]           last_grant_reg;
  logic                       mem_we_reg;
  logic [ADDR_WIDTH-1:0]      mem_addr_reg;
  logic [DATA_WIDTH-1:0]      mem_data_reg;
  logic [NUM_REQ-1:0]         wr_done_reg;

  // ---------------------------------------------------------------------------
  // One FIFO per requester
  // ---------------------------------------------------------------------------
  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_fifo
    logic [ENTRY_W-1:0] entry_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]   wr_ptr_reg;
    logic [PTR_W-1:0]   rd_ptr_reg;
    logic [CNT_W-1:0]   count_reg;
    logic [CNT_W-1:0]   count_next;
    logic               overflow_reg;
    logic               full;
    logic               pop;
    logic               push;

    assign full = (count_reg == CNT_W'(FIFO_DEPTH));
    assign pop  = grant_onehot[gi];
    // A full FIFO still accepts a push when its head leaves in the same cycle,
    // because the slot being freed is the one the new entry lands in.
    assign push = req_we[gi] && (!full || pop);

    // Occupancy after this edge: +1 on push, -1 on pop, unchanged on both
    always_comb begin
      count_next = count_reg;
      if (push && !pop) begin
        count_next = count_reg + CNT_W'(1);
      end else if (!push && pop) begin
        count_next = count_reg - CNT_W'(1);
      end
    end

    // Entry storage; contents need no reset since the pointers define validity
    always_ff @(posedge clk) begin
      if (push) begin
        entry_mem[wr_ptr_reg] <= {req_addr[gi*ADDR_WIDTH +: ADDR_WIDTH],
                                  req_data[gi*DATA_WIDTH +: DATA_WIDTH]};
      end
    end

    // Pointer, occupancy and sticky overflow bookkeeping
    always_ff @(posedge clk) begin
      if (rst) begin
        wr_ptr_reg   <= '0;
        rd_ptr_reg   <= '0;
        count_reg    <= '0;
        overflow_reg <= 1'b0;
      end else begin
        if (push) begin
          wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
        end
        if (pop) begin
          rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
        end
        count_reg <= count_next;
        if (req_we[gi] && full && !pop) begin
          overflow_reg <= 1'b1;
        end
      end
    end

    assign head_flat[gi*ENTRY_W +: ENTRY_W] = entry_mem[rd_ptr_reg];
    assign nonempty[gi]                     = (count_reg != '0);
    assign overflow[gi]                     = overflow_reg;
  end

  // ---------------------------------------------------------------------------
  // Arbiter
  // ---------------------------------------------------------------------------

  // Round-robin search starting one past the previous winner, with wrap
  always_comb begin
    int cand;
    cand        = 0;
    grant_valid = 1'b0;
    grant_idx   = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand = int'(last_grant_reg) + k;
      if (cand >= NUM_REQ) begin
        cand = cand - NUM_REQ;
      end
      if (!grant_valid && nonempty[IDX_W'(cand)]) begin
        grant_valid = 1'b1;
        grant_idx   = IDX_W'(cand);
      end
    end
  end

  // Decode the winner into a pop strobe and select its head entry
  always_comb begin
    grant_onehot = '0;
    grant_entry  = '0;
    if (grant_valid) begin
      grant_onehot[grant_idx] = 1'b1;
    end
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant_idx == IDX_W'(i)) begin
        grant_entry = head_flat[i*ENTRY_W +: ENTRY_W];
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Output stage
  // ---------------------------------------------------------------------------

  // Register the popped entry toward map_mem; address and data hold when idle
  always_ff @(posedge clk) begin
    if (rst) begin
      mem_we_reg     <= 1'b0;
      mem_addr_reg   <= '0;
      mem_data_reg   <= '0;
      wr_done_reg    <= '0;
      last_grant_reg <= IDX_W'(NUM_REQ - 1);
    end else begin
      mem_we_reg  <= grant_valid;
      wr_done_reg <= grant_onehot;
      if (grant_valid) begin
        mem_addr_reg   <= grant_entry[DATA_WIDTH +: ADDR_WIDTH];
        mem_data_reg   <= grant_entry[0 +: DATA_WIDTH];
        last_grant_reg <= grant_idx;
      end
    end
  end

  assign mem_we   = mem_we_reg;
  assign mem_addr = mem_addr_reg;
  assign mem_data = mem_data_reg;
  assign wr_done  = wr_done_reg;
  assign busy     = (|nonempty) || mem_we_reg;

endmodule

// File: tb/tb_map_write_arbiter.sv
// Bench for map_write_arbiter: a queue-based reference model checked every
// cycle, plus directed scenarios with hand-computed literal expectations.
module tb_map_write_arbiter;

  localparam int N = 4;
  localparam int D = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic [N-1:0]  req_we;
  logic [N*8-1:0] req_addr;
  logic [N*2-1:0] req_data;
  logic          mem_we;
  logic [7:0]    mem_addr;
  logic [1:0]    mem_data;
  logic [N-1:0]  wr_done;
  logic [N-1:0]  overflow;
  logic          busy;

  int tests = 0;
  int fails = 0;

  // Reference model state
  logic [9:0] mq [N][$];
  int         last_g;
  logic       exp_we;
  logic [7:0] exp_addr;
  logic [1:0] exp_data;
  logic [3:0] exp_done;
  logic [3:0] exp_ovf;
  logic       exp_busy;
  bit         model_on = 1'b0;
  logic [7:0] seen3 [$];

  map_write_arbiter #(
    .NUM_REQ(N), .ADDR_WIDTH(8), .DATA_WIDTH(2), .FIFO_DEPTH(D)
  ) dut (
    .clk(clk), .rst(rst), .req_we(req_we), .req_addr(req_addr),
    .req_data(req_data), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_data(mem_data), .wr_done(wr_done), .overflow(overflow), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    tests++;
    if (act !== expv) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, expv, $time);
    end
  endtask

  task automatic set_req(input int i, input logic [7:0] a, input logic [1:0] d);
    req_we[i]         = 1'b1;
    req_addr[i*8 +: 8] = a;
    req_data[i*2 +: 2] = d;
  endtask

  // Advance to the next falling edge (one rising edge consumed), then idle inputs
  task automatic tick();
    @(negedge clk);
    req_we = '0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  // Model update and compare, 1 time unit after every rising edge
  always begin : cmp
    int win;
    int c;
    logic [9:0] ent;
    @(posedge clk);
    #1;
    if (rst) begin
      for (int i = 0; i < N; i++) mq[i].delete();
      exp_we   = 1'b0;
      exp_addr = '0;
      exp_data = '0;
      exp_done = '0;
      exp_ovf  = '0;
      last_g   = N - 1;
      model_on = 1'b1;
    end else if (model_on) begin
      win = -1;
      for (int k = 1; k <= N; k++) begin
        c = (last_g + k) % N;
        if (win < 0 && mq[c].size() > 0) win = c;
      end
      if (win >= 0) begin
        ent      = mq[win].pop_front();
        exp_we   = 1'b1;
        exp_addr = ent[9:2];
        exp_data = ent[1:0];
        exp_done = 4'(1 << win);
        last_g   = win;
      end else begin
        exp_we   = 1'b0;
        exp_done = '0;
      end
      // Pushes see the queue after this cycle's pop, so full+pop is accepted
      for (int i = 0; i < N; i++) begin
        if (req_we[i]) begin
          if (mq[i].size() < D) mq[i].push_back({req_addr[i*8 +: 8], req_data[i*2 +: 2]});
          else exp_ovf[i] = 1'b1;
        end
      end
    end
    if (model_on) begin
      exp_busy = exp_we;
      for (int i = 0; i < N; i++) if (mq[i].size() > 0) exp_busy = 1'b1;
      check("mem_we",   32'(mem_we),   32'(exp_we));
      check("mem_addr", 32'(mem_addr), 32'(exp_addr));
      check("mem_data", 32'(mem_data), 32'(exp_data));
      check("wr_done",  32'(wr_done),  32'(exp_done));
      check("overflow", 32'(overflow), 32'(exp_ovf));
      check("busy",     32'(busy),     32'(exp_busy));
      if (mem_we && wr_done[3]) seen3.push_back(mem_addr);
      if (exp_we) $display("[TB] write done=%b addr=0x%02h data=%0d", exp_done, exp_addr, exp_data);
    end
  end

  initial begin
    rst      = 1'b1;
    req_we   = '0;
    req_addr = '0;
    req_data = '0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    check("rst_mem_we",   32'(mem_we),   32'd0);
    check("rst_mem_addr", 32'(mem_addr), 32'd0);
    check("rst_wr_done",  32'(wr_done),  32'd0);
    check("rst_overflow", 32'(overflow), 32'd0);
    check("rst_busy",     32'(busy),     32'd0);

    // T1 single request: two-cycle latency, one-cycle pulse, busy drops after
    set_req(2, 8'h2A, 2'b10);
    tick();
    check("t1_we_early", 32'(mem_we), 32'd0);
    tick();
    check("t1_we",      32'(mem_we),   32'd1);
    check("t1_addr",    32'(mem_addr), 32'h2A);
    check("t1_data",    32'(mem_data), 32'd2);
    check("t1_done",    32'(wr_done),  32'b0100);
    check("t1_busy",    32'(busy),     32'd1);
    tick();
    check("t1_we_off",  32'(mem_we),   32'd0);
    check("t1_done_off", 32'(wr_done), 32'd0);
    check("t1_busy_off", 32'(busy),    32'd0);

    // T3 round-robin: previous winner was 2, so order is 3, 0, 1
    set_req(0, 8'h30, 2'd1);
    set_req(1, 8'h31, 2'd2);
    set_req(3, 8'h33, 2'd3);
    tick();
    tick();
    check("t3_first_done",  32'(wr_done),  32'b1000);
    check("t3_first_addr",  32'(mem_addr), 32'h33);
    tick();
    check("t3_second_done", 32'(wr_done),  32'b0001);
    check("t3_second_addr", 32'(mem_addr), 32'h30);
    tick();
    check("t3_third_done",  32'(wr_done),  32'b0010);
    check("t3_third_addr",  32'(mem_addr), 32'h31);
    tick();
    check("t3_idle", 32'(mem_we), 32'd0);

    // T2 simultaneous after reset: requesters served 0,1,2,3 back to back
    do_reset();
    for (int k = 0; k < N; k++) set_req(k, 8'(10 + k), 2'(k));
    tick();
    for (int k = 0; k < N; k++) begin
      tick();
      check("t2_we",   32'(mem_we),   32'd1);
      check("t2_addr", 32'(mem_addr), 32'(10 + k));
      check("t2_done", 32'(wr_done),  32'(1 << k));
    end
    tick();
    check("t2_idle", 32'(mem_we), 32'd0);

    // T4 overflow: two requesters pushing every cycle outrun alternating service
    do_reset();
    for (int c = 0; c < 12; c++) begin
      set_req(0, 8'(8'h40 + c), 2'd0);
      set_req(1, 8'(8'h60 + c), 2'd1);
      tick();
    end
    check("t4_ovf_set", 32'(overflow), 32'b0011);
    for (int c = 0; c < 10; c++) tick();
    check("t4_ovf_sticky", 32'(overflow), 32'b0011);
    check("t4_drained",    32'(busy),     32'd0);
    do_reset();
    check("t4_ovf_clear",  32'(overflow), 32'd0);

    // T5 full push+pop: FIFO 3 fills while crowded out, then a push lands
    // in the cycle its head is popped and must be accepted
    seen3.delete();
    for (int c = 0; c < 5; c++) begin
      if (c < 4) begin
        for (int i = 0; i < 3; i++) set_req(i, 8'(8'h80 + 16*i + c), 2'd0);
      end
      set_req(3, 8'(8'hA0 + c), 2'd3);
      tick();
    end
    for (int c = 0; c < 16; c++) tick();
    check("t5_ovf", 32'(overflow), 32'd0);
    check("t5_count3", 32'(seen3.size()), 32'd5);
    for (int k = 0; k < 5; k++) begin
      if (k < seen3.size()) check("t5_order3", 32'(seen3[k]), 32'(8'hA0 + k));
    end

    // T6 reset mid-operation: nothing queued before reset is ever written
    do_reset();
    for (int c = 0; c < 3; c++) begin
      for (int i = 0; i < N; i++) set_req(i, 8'(8'hC0 + 4*c + i), 2'(i));
      tick();
    end
    do_reset();
    check("t6_we_post_rst", 32'(mem_we), 32'd0);
    for (int c = 0; c < 4; c++) begin
      tick();
      check("t6_we_quiet",   32'(mem_we), 32'd0);
      check("t6_busy_quiet", 32'(busy),   32'd0);
    end
    set_req(1, 8'h77, 2'd1);
    tick();
    check("t6_we_early", 32'(mem_we), 32'd0);
    tick();
    check("t6_we",   32'(mem_we),   32'd1);
    check("t6_addr", 32'(mem_addr), 32'h77);
    check("t6_done", 32'(wr_done),  32'b0010);
    tick();
    tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
